// File: rtl/riscv_mem_pkg.sv
// Shared load/store encodings, FSM state type and request payload for the
// data-memory side of the pipelined core.
package riscv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  funct3;
   } mem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one load/store: write mask, replicated write word,
// extended load result and misalign/illegal-funct3 error.
module dmem_lane_align
   import riscv_mem_pkg::*;
(
   input  logic        we,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be_c,
   output logic [31:0] wword_c,
   output logic [31:0] rdata_c,
   output logic        err_c
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   assign rbyte = rword[{addr_lo, 3'b000} +: 8];
   assign rhalf = rword[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      be_c    = '0;
      wword_c = '0;
      rdata_c = '0;
      err_c   = 1'b0;
      case (funct3)
         F3_B: begin
            be_c    = 4'(4'b0001 << addr_lo);
            wword_c = {4{wdata[7:0]}};
            rdata_c = {{24{rbyte[7]}}, rbyte};
         end
         F3_H: begin
            err_c   = addr_lo[0];
            be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wword_c = {2{wdata[15:0]}};
            rdata_c = {{16{rhalf[15]}}, rhalf};
         end
         F3_W: begin
            err_c   = (addr_lo != 2'b00);
            be_c    = 4'b1111;
            wword_c = wdata;
            rdata_c = rword;
         end
         F3_BU: begin
            err_c   = we;
            rdata_c = {24'd0, rbyte};
         end
         F3_HU: begin
            err_c   = we | addr_lo[0];
            rdata_c = {16'd0, rhalf};
         end
         default: err_c = 1'b1;
      endcase
      // Errors never write and never return data; stores return zero.
      if (err_c || !we) be_c = '0;
      if (err_c || we) rdata_c = '0;
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles,
// performs the lane access on a word array and emits a one-cycle response.
module dmem_responder
   import riscv_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW    = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 4;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   mem_req_t         cap;
   logic             accept_c;
   logic             exec_c;

   logic [31:0]      mem [DEPTH_WORDS];
   logic [AW-1:0]    idx;
   logic [31:0]      rword;
   logic [3:0]       be_c;
   logic [31:0]      wword_c;
   logic [31:0]      rdata_c;
   logic             err_c;
   logic             unused_addr_hi;

   // Upper address bits fold away: accesses wrap modulo the array size.
   assign idx            = cap.addr[AW+1:2];
   assign unused_addr_hi = &{1'b0, cap.addr[31:AW+2]};
   assign rword          = mem[idx];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (req_valid) state_nx = ST_BUSY;
         ST_BUSY: if (cnt == '0) state_nx = ST_RESP;
         ST_RESP: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      accept_c  = 1'b0;
      exec_c    = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = ~reset;
            accept_c  = req_valid;
         end
         ST_BUSY: exec_c = (cnt == '0);
         default: ;
      endcase
   end

   // Request capture, latency countdown and registered response.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cap        <= '0;
         cnt        <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (accept_c) begin
            cap <= '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
            cnt <= CNT_W'(LATENCY - 1);
         end else if (state == ST_BUSY && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         resp_valid <= exec_c;
         if (exec_c) begin
            resp_rdata <= rdata_c;
            resp_err   <= err_c;
         end
      end
   end

   // Array contents are deliberately not reset.
   always_ff @(posedge clock) begin
      if (exec_c) begin
         for (int b = 0; b < 4; b++) begin
            if (be_c[b]) mem[idx][8*b +: 8] <= wword_c[8*b +: 8];
         end
      end
   end

   dmem_lane_align u_align (
      .we      (cap.we),
      .addr_lo (cap.addr[1:0]),
      .funct3  (cap.funct3),
      .wdata   (cap.wdata),
      .rword   (rword),
      .be_c    (be_c),
      .wword_c (wword_c),
      .rdata_c (rdata_c),
      .err_c   (err_c)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model, directed
// plan cases, reset abort, back-to-back spacing and random traffic.
module tb_dmem_responder;
   import riscv_mem_pkg::*;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned LAT   = 2;
   localparam int unsigned MEMB  = DEPTH * 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int unsigned cyc;
   } exp_t;

   exp_t        q[$];
   logic [7:0]  mm [MEMB];
   int          total = 0;
   int          bad = 0;
   int          n_resp = 0;
   int          n_push = 0;
   int unsigned cyc = 0;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference model working on a flat byte array with plain arithmetic.
   function automatic void model(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] f3,
                                 output logic [31:0] rd, output logic e);
      int unsigned a;
      int          sz;
      logic [31:0] v;
      a  = addr % MEMB;
      rd = '0;
      e  = 1'b0;
      v  = '0;
      case (f3)
         3'd0: sz = 1;
         3'd1: sz = 2;
         3'd2: sz = 4;
         3'd4: begin sz = 1; e = we; end
         3'd5: begin sz = 2; e = we; end
         default: begin sz = 1; e = 1'b1; end
      endcase
      if (a % sz != 0) e = 1'b1;
      if (!e) begin
         if (we) begin
            for (int i = 0; i < sz; i++) mm[a+i] = wdata[8*i +: 8];
         end else begin
            for (int i = 0; i < sz; i++) v = v | (32'(mm[a+i]) << (8*i));
            if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
            rd = v;
         end
      end
   endfunction

   // Monitor: every response pulse is matched against the oldest expectation.
   always @(negedge clock) begin : mon
      exp_t x;
      if (!reset && resp_valid) begin
         n_resp++;
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: got resp_valid=1 want no response");
         end else begin
            x = q.pop_front();
            check("rdata", resp_rdata, x.rdata);
            check("err", 32'(resp_err), 32'(x.err));
            check("latency_cycle", 32'(cyc), 32'(x.cyc));
         end
      end
   end

   // Called and returns at a falling edge; acc reports the acceptance cycle.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input bit push, input bit keep,
                        output int unsigned acc);
      int          w;
      logic [31:0] rd;
      logic        e;
      w          = 0;
      acc        = 0;
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wdata;
      req_funct3 = f3;
      while (!req_ready && w < 100) begin
         @(negedge clock);
         w++;
      end
      if (!req_ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got req_ready=0 want 1 within 100 cycles");
         req_valid = 1'b0;
         return;
      end
      acc = cyc + 1;
      @(posedge clock);
      if (push) begin
         model(we, addr, wdata, f3, rd, e);
         q.push_back('{rd, e, acc + LAT});
         n_push++;
      end
      @(negedge clock);
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic go(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] f3);
      int unsigned acc;
      issue(we, addr, wdata, f3, 1'b1, 1'b0, acc);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (q.size() != 0 && w < 50) begin
         @(negedge clock);
         w++;
      end
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", q.size());
      end
      repeat (2) @(negedge clock);
   endtask

   initial begin : stim
      int unsigned acc;
      int unsigned prev;
      logic [31:0] r;
      #2;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      check("post_rst_req_ready", 32'(req_ready), 32'd1);
      @(negedge clock);

      go(1'b1, 32'h10, 32'hDEADBEEF, F3_W);
      go(1'b0, 32'h10, 32'h0, F3_W);
      go(1'b0, 32'h13, 32'h0, F3_B);
      go(1'b0, 32'h13, 32'h0, F3_BU);
      go(1'b0, 32'h12, 32'h0, F3_H);
      go(1'b0, 32'h10, 32'h0, F3_HU);
      go(1'b1, 32'h11, 32'h55, F3_B);
      go(1'b0, 32'h10, 32'h0, F3_W);
      go(1'b1, 32'h12, 32'h1234, F3_H);
      go(1'b0, 32'h10, 32'h0, F3_W);
      go(1'b0, 32'h12, 32'h0, F3_W);
      go(1'b1, 32'h11, 32'hFFFF, F3_H);
      go(1'b0, 32'h10, 32'h0, 3'd3);
      go(1'b1, 32'h10, 32'hFFFFFFFF, F3_BU);
      go(1'b0, 32'h10, 32'h0, F3_W);
      go(1'b1, 32'h1010, 32'hA5A5A5A5, F3_W);
      go(1'b0, 32'h10, 32'h0, F3_W);
      drain();

      // Reset lands while the store is still counting down.
      go(1'b1, 32'h20, 32'h0, F3_W);
      drain();
      issue(1'b1, 32'h20, 32'h11111111, F3_W, 1'b0, 1'b0, acc);
      @(posedge clock);
      #1 reset = 1'b1;
      #1;
      check("in_rst_req_ready", 32'(req_ready), 32'd0);
      check("in_rst_resp_valid", 32'(resp_valid), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      check("abort_req_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("abort_no_resp", 32'(resp_valid), 32'd0);
      end
      go(1'b0, 32'h20, 32'h0, F3_W);
      drain();

      for (int w = 0; w < 64; w++) go(1'b1, 32'(w * 4), $urandom, F3_W);
      drain();

      // req_valid held high across several back-to-back requests.
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         r = $urandom;
         issue(r[0], (r & 32'hFFFF_F000) | 32'($urandom_range(0, 255)), $urandom,
               3'($urandom_range(0, 5)), 1'b1, 1'b1, acc);
         if (i > 0) check("accept_spacing", 32'(acc - prev), 32'(LAT + 2));
         prev = acc;
      end
      req_valid = 1'b0;
      drain();

      for (int i = 0; i < 300; i++) begin
         r = $urandom;
         go(r[0], (r & 32'hFFFF_F000) | 32'($urandom_range(0, 255)), $urandom,
            3'($urandom_range(0, 7)));
      end
      drain();

      check("resp_count", 32'(n_resp), 32'(n_push));
      check("queue_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
